// File: rtl/bp_nonsynth_if_monitor.sv
// Runtime protocol monitor for valid/ready_and channels.
// Watches each channel for valid-drop, payload change while stalled, and
// stall timeout; counts handshakes and latches the first error seen.
// Sits beside a DUT in simulation only and never drives it.
module bp_nonsynth_if_monitor #(
    parameter int num_channels_p   = 4,
    parameter int data_width_p     = 64,
    parameter int timeout_p        = 1024,
    parameter int count_width_p    = 32,
    parameter int check_data_p     = 1,
    parameter int fatal_on_error_p = 0,
    // 0 silences the per-violation $error messages; the sticky outputs and
    // the $fatal-on-first-error behaviour are unaffected.
    parameter int report_p         = 1,
    localparam int ch_width_lp     = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     en_i,
    input  logic [num_channels_p-1:0]                v_i,
    input  logic [num_channels_p-1:0]                ready_and_i,
    input  logic [num_channels_p*data_width_p-1:0]   data_i,
    output logic                                     error_o,
    output logic [ch_width_lp-1:0]                   error_ch_o,
    output logic [1:0]                               error_code_o,
    output logic [num_channels_p*count_width_p-1:0]  count_o
);

    localparam int stall_width_lp = $clog2(timeout_p + 1);

    localparam logic [1:0] code_none_lp    = 2'd0;
    localparam logic [1:0] code_vdrop_lp   = 2'd1;
    localparam logic [1:0] code_dchange_lp = 2'd2;
    localparam logic [1:0] code_timeout_lp = 2'd3;

    logic [num_channels_p-1:0] pending_r;
    logic [data_width_p-1:0]   data_r   [num_channels_p];
    logic [stall_width_lp-1:0] stall_r  [num_channels_p];
    logic [count_width_p-1:0]  count_r  [num_channels_p];
    logic [1:0]                code     [num_channels_p];

    logic                   any_err;
    logic [ch_width_lp-1:0] first_ch;
    logic [1:0]             first_code;

    logic                   error_r;
    logic [ch_width_lp-1:0] error_ch_r;
    logic [1:0]             error_code_r;

    // Parameter sanity checks; a bad configuration stops the simulation at time 0.
    initial begin
        if (num_channels_p < 1) $fatal(1, "bp_nonsynth_if_monitor: num_channels_p must be >= 1");
        if (timeout_p < 2)      $fatal(1, "bp_nonsynth_if_monitor: timeout_p must be >= 2");
        if (data_width_p < 1)   $fatal(1, "bp_nonsynth_if_monitor: data_width_p must be >= 1");
    end

    // Per-channel violation code for this cycle, judged against last cycle's state.
    always_comb begin
        for (int c = 0; c < num_channels_p; c++) begin
            code[c] = code_none_lp;
            if (en_i) begin
                if (pending_r[c] && !v_i[c])
                    code[c] = code_vdrop_lp;
                else if ((check_data_p != 0) && pending_r[c] && v_i[c]
                         && (data_i[c*data_width_p +: data_width_p] != data_r[c]))
                    code[c] = code_dchange_lp;
                else if (v_i[c] && !ready_and_i[c]
                         && (stall_r[c] == stall_width_lp'(timeout_p - 1)))
                    code[c] = code_timeout_lp;
            end
        end
    end

    // Lowest-numbered channel with a violation this cycle.
    always_comb begin
        any_err    = 1'b0;
        first_ch   = '0;
        first_code = code_none_lp;
        for (int c = 0; c < num_channels_p; c++) begin
            if (!any_err && (code[c] != code_none_lp)) begin
                any_err    = 1'b1;
                first_ch   = ch_width_lp'(c);
                first_code = code[c];
            end
        end
    end

    // Channel tracking state, handshake counters and the sticky first-error record.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_r    <= '0;
            error_r      <= 1'b0;
            error_ch_r   <= '0;
            error_code_r <= code_none_lp;
            for (int c = 0; c < num_channels_p; c++) begin
                data_r[c]  <= '0;
                stall_r[c] <= '0;
                count_r[c] <= '0;
            end
        end else begin
            if (any_err && !error_r) begin
                error_r      <= 1'b1;
                error_ch_r   <= first_ch;
                error_code_r <= first_code;
            end
            for (int c = 0; c < num_channels_p; c++) begin
                if (!en_i || !v_i[c]) begin
                    pending_r[c] <= 1'b0;
                    stall_r[c]   <= '0;
                end else if (ready_and_i[c]) begin
                    pending_r[c] <= 1'b0;
                    stall_r[c]   <= '0;
                    if (count_r[c] != {count_width_p{1'b1}})
                        count_r[c] <= count_r[c] + count_width_p'(1);
                end else begin
                    pending_r[c] <= 1'b1;
                    data_r[c]    <= data_i[c*data_width_p +: data_width_p];
                    if (stall_r[c] != stall_width_lp'(timeout_p))
                        stall_r[c] <= stall_r[c] + stall_width_lp'(1);
                end
            end
        end
    end

    // Message for every violation; the very first one may end the run.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int c = 0; c < num_channels_p; c++) begin
                if (code[c] != code_none_lp) begin
                    if ((fatal_on_error_p != 0) && !error_r)
                        $fatal(1, "[%0t] if_monitor: channel %0d error code %0d", $time, c, code[c]);
                    else if (report_p != 0)
                        $error("[%0t] if_monitor: channel %0d error code %0d", $time, c, code[c]);
                end
            end
        end
    end

    // Flatten the per-channel counters onto the output bus.
    always_comb begin
        count_o = '0;
        for (int c = 0; c < num_channels_p; c++)
            count_o[c*count_width_p +: count_width_p] = count_r[c];
    end

    assign error_o      = error_r;
    assign error_ch_o   = error_ch_r;
    assign error_code_o = error_code_r;

    // End-of-simulation summary of traffic and error status.
    final begin
        for (int c = 0; c < num_channels_p; c++)
            $display("if_monitor %m: channel %0d handshakes %0d", c, count_r[c]);
        $display("if_monitor %m: error=%0d channel=%0d code=%0d", error_r, error_ch_r, error_code_r);
    end

endmodule

// File: tb/tb_bp_nonsynth_if_monitor.sv
// Bench for bp_nonsynth_if_monitor: three instances (payload check on,
// payload check off, 2-bit counters) share one stimulus stream and are
// compared every cycle against a behavioural model of the channel rules.
module tb_bp_nonsynth_if_monitor;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int TO  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             en;
    logic [NCH-1:0]   v;
    logic [NCH-1:0]   rdy;
    logic [NCH*DW-1:0] data;

    logic         err_a, err_b, err_c;
    logic [1:0]   ech_a, ech_b, ech_c;
    logic [1:0]   ecode_a, ecode_b, ecode_c;
    logic [NCH*32-1:0] cnt_a, cnt_b;
    logic [NCH*2-1:0]  cnt_c;

    bp_nonsynth_if_monitor #(.num_channels_p(NCH), .data_width_p(DW), .timeout_p(TO),
        .count_width_p(32), .check_data_p(1), .fatal_on_error_p(0), .report_p(0)) u_chk (
        .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .ready_and_i(rdy), .data_i(data),
        .error_o(err_a), .error_ch_o(ech_a), .error_code_o(ecode_a), .count_o(cnt_a));

    bp_nonsynth_if_monitor #(.num_channels_p(NCH), .data_width_p(DW), .timeout_p(TO),
        .count_width_p(32), .check_data_p(0), .fatal_on_error_p(0), .report_p(0)) u_nochk (
        .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .ready_and_i(rdy), .data_i(data),
        .error_o(err_b), .error_ch_o(ech_b), .error_code_o(ecode_b), .count_o(cnt_b));

    bp_nonsynth_if_monitor #(.num_channels_p(NCH), .data_width_p(DW), .timeout_p(TO),
        .count_width_p(2), .check_data_p(1), .fatal_on_error_p(0), .report_p(0)) u_sat (
        .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .ready_and_i(rdy), .data_i(data),
        .error_o(err_c), .error_ch_o(ech_c), .error_code_o(ecode_c), .count_o(cnt_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: per instance, length of the current stall run,
    // the payload last offered while stalled, handshakes seen, first error.
    int              m_stall [3][NCH];
    logic [DW-1:0]   m_held  [3][NCH];
    longint unsigned m_cnt   [3][NCH];
    bit              m_err   [3];
    int              m_ch    [3];
    int              m_code  [3];
    bit              m_datachk [3] = '{1'b1, 1'b0, 1'b1};
    longint unsigned m_max     [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_err[k] = 0; m_ch[k] = 0; m_code[k] = 0;
                for (int c = 0; c < NCH; c++) begin
                    m_stall[k][c] = 0; m_held[k][c] = '0; m_cnt[k][c] = 0;
                end
            end else if (!en) begin
                for (int c = 0; c < NCH; c++) m_stall[k][c] = 0;
            end else begin
                int found_code = 0;
                int found_ch   = 0;
                for (int c = 0; c < NCH; c++) begin
                    logic [DW-1:0] d = data[c*DW +: DW];
                    bit was_stalled = (m_stall[k][c] > 0);
                    int cd = 0;
                    if (was_stalled && !v[c]) cd = 1;
                    else if (m_datachk[k] && was_stalled && v[c] && d != m_held[k][c]) cd = 2;
                    else if (v[c] && !rdy[c] && m_stall[k][c] == TO - 1) cd = 3;
                    if (cd != 0 && found_code == 0) begin
                        found_code = cd; found_ch = c;
                    end
                    if (v[c] && rdy[c]) begin
                        m_stall[k][c] = 0;
                        if (m_cnt[k][c] < m_max[k]) m_cnt[k][c]++;
                    end else if (v[c]) begin
                        m_stall[k][c]++;
                        m_held[k][c] = d;
                    end else begin
                        m_stall[k][c] = 0;
                    end
                end
                if (found_code != 0 && !m_err[k]) begin
                    m_err[k] = 1; m_ch[k] = found_ch; m_code[k] = found_code;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a_err",  err_a,   m_err[0]);
        chk("a_ch",   ech_a,   m_ch[0]);
        chk("a_code", ecode_a, m_code[0]);
        chk("b_err",  err_b,   m_err[1]);
        chk("b_ch",   ech_b,   m_ch[1]);
        chk("b_code", ecode_b, m_code[1]);
        chk("c_err",  err_c,   m_err[2]);
        chk("c_ch",   ech_c,   m_ch[2]);
        chk("c_code", ecode_c, m_code[2]);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("a_cnt%0d", c), cnt_a[c*32 +: 32], m_cnt[0][c]);
            chk($sformatf("b_cnt%0d", c), cnt_b[c*32 +: 32], m_cnt[1][c]);
            chk($sformatf("c_cnt%0d", c), cnt_c[c*2 +: 2],   m_cnt[2][c]);
        end
    endtask

    // One clock: the edge consumes the inputs, the model follows, outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        rst = 1'b0; en = 1'b1; v = '0; rdy = '0; data = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_ch(input int c, input logic vv, input logic rr, input logic [DW-1:0] d);
        v[c] = vv; rdy[c] = rr; data[c*DW +: DW] = d;
    endtask

    logic [NCH-1:0] prev_v, prev_r;

    initial begin
        idle();
        rst = 1'b1;
        step();
        chk("rst_err", err_a, 0);
        chk("rst_code", ecode_a, 0);
        chk("rst_cnt", cnt_a, 0);
        rst = 1'b0;

        // Five back-to-back handshakes on channel 0.
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 1'b1, 1'b1, DW'($urandom)); step();
        end
        idle(); step();
        chk("hs_cnt0", cnt_a[31:0], 5);
        chk("hs_cnt1", cnt_a[63:32], 0);
        chk("hs_err", err_a, 0);
        chk("hs_sat", cnt_c[1:0], 3);

        // Valid drop on channel 1.
        do_reset();
        set_ch(1, 1'b1, 1'b0, 16'hA5); step();
        set_ch(1, 1'b0, 1'b0, 16'h00); step();
        chk("vdrop_err", err_a, 1);
        chk("vdrop_ch", ech_a, 1);
        chk("vdrop_code", ecode_a, 1);
        idle(); step();

        // Payload change while stalled on channel 2.
        do_reset();
        set_ch(2, 1'b1, 1'b0, 16'h10); step();
        set_ch(2, 1'b1, 1'b0, 16'h11); step();
        chk("dchg_code", ecode_a, 2);
        chk("dchg_ch", ech_a, 2);
        chk("dchg_nochk", err_b, 0);
        set_ch(2, 1'b1, 1'b1, 16'h11); step();
        idle(); step();

        // Timeout on channel 3 after eight stalled cycles.
        do_reset();
        for (int i = 0; i < TO; i++) begin
            set_ch(3, 1'b1, 1'b0, 16'h33); step();
            if (i == TO - 2) chk("to_early", err_a, 0);
        end
        chk("to_code", ecode_a, 3);
        chk("to_ch", ech_a, 3);
        idle(); step();

        // Ready arrives on the seventh cycle: no timeout, one handshake.
        do_reset();
        for (int i = 0; i < TO; i++) begin
            if (i < 6)       set_ch(3, 1'b1, 1'b0, 16'h44);
            else if (i == 6) set_ch(3, 1'b1, 1'b1, 16'h44);
            else             set_ch(3, 1'b0, 1'b0, 16'h00);
            step();
        end
        chk("to_avoid_err", err_a, 0);
        chk("to_avoid_cnt", cnt_a[127:96], 1);

        // Same-cycle ch0 timeout and ch1 drop, then a later ch2 payload change.
        do_reset();
        for (int i = 0; i < TO; i++) begin
            set_ch(0, 1'b1, 1'b0, 16'h0F);
            if (i == 6) set_ch(1, 1'b1, 1'b0, 16'h1F);
            if (i == 7) set_ch(1, 1'b0, 1'b0, 16'h00);
            step();
        end
        chk("pri_ch", ech_a, 0);
        chk("pri_code", ecode_a, 3);
        idle(); step();
        set_ch(2, 1'b1, 1'b0, 16'h01); step();
        set_ch(2, 1'b1, 1'b0, 16'h02); step();
        chk("sticky_ch", ech_a, 0);
        chk("sticky_code", ecode_a, 3);
        chk("sticky_err", err_a, 1);
        idle(); step();

        // Reset during a stall discards it.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 1'b1, 1'b0, 16'h77); step();
        end
        rst = 1'b1; step();
        idle(); step(); step();
        chk("rstmid_err", err_a, 0);
        chk("rstmid_code", ecode_a, 0);

        // Disable clears the pending stall: changed payload on re-enable is legal.
        set_ch(1, 1'b1, 1'b0, 16'h05); step();
        en = 1'b0; set_ch(1, 1'b1, 1'b0, 16'h06); step();
        en = 1'b1; set_ch(1, 1'b1, 1'b0, 16'h07); step();
        chk("en_err", err_a, 0);
        set_ch(1, 1'b1, 1'b1, 16'h07); step();
        idle(); step();

        // Randomised traffic.
        prev_v = '0; prev_r = '0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 24) != 0);
            for (int c = 0; c < NCH; c++) begin
                logic vv, rr;
                logic [DW-1:0] d;
                if (prev_v[c] && !prev_r[c]) begin
                    vv = ($urandom_range(0, 19) != 0);
                    d  = ($urandom_range(0, 19) != 0) ? data[c*DW +: DW] : DW'($urandom);
                    rr = ($urandom_range(0, 3) != 0);
                end else begin
                    vv = $urandom_range(0, 1);
                    d  = DW'($urandom);
                    rr = ($urandom_range(0, 2) == 0);
                end
                set_ch(c, vv, rr, d);
            end
            prev_v = v; prev_r = rdy;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
